// File: rtl/fmps_readout_sequencer.sv
// Per-FA-cycle readout of the FMPS packet store: waits for the packets, freezes the store, scans it and streams each present word.
// Present words cost at least 4 clocks (1-clock DPRAM read latency); absent indices cost 2. The beat holds until M_TREADY.
module fmps_readout_sequencer #(
  parameter int          INDEX_WIDTH    = 5,
  parameter int          TIMEOUT_CYCLES = 300,
  parameter logic [15:0] DATA_MAGIC     = 16'hCACA
) (
  input  logic                        auroraClk,
  input  logic                        auroraReset,
  input  logic                        enable,
  input  logic                        FAstrobe,
  input  logic [INDEX_WIDTH:0]        expectedCount,
  input  logic [(2**INDEX_WIDTH)-1:0] fmpsBitmap,
  input  logic [INDEX_WIDTH:0]        fmpsCounter,
  output logic                        allFMPSpresent,
  output logic [INDEX_WIDTH-1:0]      readoutAddress,
  input  logic [31:0]                 readoutFMPS,
  output logic                        M_TVALID,
  output logic [31:0]                 M_TDATA,
  output logic                        M_TLAST,
  input  logic                        M_TREADY,
  output logic                        cycleDone,
  output logic [1:0]                  cycleStatus,
  output logic [7:0]                  cycleCounter,
  output logic [15:0]                 errorCount
);

  localparam int                     DEPTH       = 2**INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(DEPTH-1);
  localparam logic [15:0]            TIMER_LIMIT = 16'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ADDR, S_SETTLE, S_CHECK, S_SEND, S_DONE
  } state_t;

  state_t      state, stateNext;
  logic [15:0] timer;
  logic        timeoutFlag, headerFlag, strobePending;

  logic startCycle, overrun, reportDone, freeze, advance, capture;
  logic handshake, pendingNow, countReached, waitOver, headerBad, lastWord;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge auroraClk) begin
    if (auroraReset) state <= S_IDLE;
    else             state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    startCycle   = 1'b0;
    overrun      = 1'b0;
    reportDone   = 1'b0;
    freeze       = 1'b0;
    advance      = 1'b0;
    capture      = 1'b0;
    handshake    = M_TVALID && M_TREADY;
    pendingNow   = strobePending || FAstrobe;
    countReached = fmpsCounter >= expectedCount;
    waitOver     = countReached || (timer == TIMER_LIMIT);
    headerBad    = readoutFMPS[31] || readoutFMPS[30] || readoutFMPS[29]
                || (readoutFMPS[28:24] != 5'(readoutAddress))
                || (readoutFMPS[23:8] != DATA_MAGIC)
                || (readoutFMPS[7:0] != cycleCounter);
    lastWord     = ((fmpsBitmap >> readoutAddress) >> 1) == '0;

    if (!enable) begin
      // An in-flight beat is allowed to complete before dropping to IDLE
      if (state != S_SEND || handshake) stateNext = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (FAstrobe) begin
            startCycle = 1'b1;
            stateNext  = S_WAIT;
          end
        end
        S_WAIT, S_ADDR, S_SETTLE, S_CHECK: begin
          if (FAstrobe) begin
            overrun    = 1'b1;
            startCycle = 1'b1;
            stateNext  = S_WAIT;
          end else if (state == S_WAIT) begin
            if (waitOver) begin
              freeze    = 1'b1;
              stateNext = S_SETTLE;
            end
          end else if (state == S_ADDR) begin
            if (readoutAddress == LAST_INDEX) begin
              stateNext = S_DONE;
            end else begin
              advance   = 1'b1;
              stateNext = S_SETTLE;
            end
          end else if (state == S_SETTLE) begin
            stateNext = fmpsBitmap[readoutAddress] ? S_CHECK : S_ADDR;
          end else begin
            capture   = 1'b1;
            stateNext = S_SEND;
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (pendingNow) begin
              overrun    = 1'b1;
              startCycle = 1'b1;
              stateNext  = S_WAIT;
            end else begin
              stateNext = M_TLAST ? S_DONE : S_ADDR;
            end
          end
        end
        S_DONE: begin
          reportDone = 1'b1;
          if (FAstrobe) begin
            startCycle = 1'b1;
            stateNext  = S_WAIT;
          end else begin
            stateNext = S_IDLE;
          end
        end
        default: stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge auroraClk) begin
    if (auroraReset) begin
      allFMPSpresent <= 1'b0;
      readoutAddress <= '0;
      M_TVALID       <= 1'b0;
      M_TDATA        <= '0;
      M_TLAST        <= 1'b0;
      cycleDone      <= 1'b0;
      cycleStatus    <= 2'd0;
      cycleCounter   <= 8'd0;
      errorCount     <= 16'd0;
      timer          <= 16'd0;
      timeoutFlag    <= 1'b0;
      headerFlag     <= 1'b0;
      strobePending  <= 1'b0;
    end else begin
      cycleDone <= 1'b0;
      if (state == S_WAIT) timer <= timer + 16'd1;
      if (startCycle) begin
        cycleCounter   <= cycleCounter + 8'd1;
        allFMPSpresent <= 1'b0;
        timer          <= 16'd0;
        timeoutFlag    <= 1'b0;
        headerFlag     <= 1'b0;
        strobePending  <= 1'b0;
      end
      if (overrun) begin
        cycleDone   <= 1'b1;
        cycleStatus <= 2'd3;
        errorCount  <= satInc(errorCount);
      end
      if (reportDone) begin
        cycleDone   <= 1'b1;
        cycleStatus <= headerFlag ? 2'd2 : (timeoutFlag ? 2'd1 : 2'd0);
      end
      if (freeze) begin
        allFMPSpresent <= 1'b1;
        readoutAddress <= '0;
        timeoutFlag    <= !countReached;
      end
      if (advance) readoutAddress <= readoutAddress + INDEX_WIDTH'(1);
      if (capture) begin
        M_TDATA  <= readoutFMPS;
        M_TLAST  <= lastWord;
        M_TVALID <= 1'b1;
        if (headerBad) begin
          headerFlag <= 1'b1;
          errorCount <= satInc(errorCount);
        end
      end
      // A strobe during a stalled beat closes the frame on that beat
      if (state == S_SEND && enable && FAstrobe && !handshake) begin
        strobePending <= 1'b1;
        M_TLAST       <= 1'b1;
      end
      if (handshake) M_TVALID <= 1'b0;
      if (!enable) begin
        allFMPSpresent <= 1'b0;
        strobePending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fmps_readout_sequencer.sv
// Directed bench for fmps_readout_sequencer: table of whole FA cycles plus hand-written overrun and reset sequences.
module tb_fmps_readout_sequencer;

  logic        auroraClk = 1'b0;
  logic        auroraReset, enable, FAstrobe;
  logic [5:0]  expectedCount, fmpsCounter;
  logic [31:0] fmpsBitmap;
  logic        allFMPSpresent;
  logic [4:0]  readoutAddress;
  logic [31:0] readoutFMPS = 32'd0;
  logic        M_TVALID, M_TLAST, M_TREADY;
  logic [31:0] M_TDATA;
  logic        cycleDone;
  logic [1:0]  cycleStatus;
  logic [7:0]  cycleCounter;
  logic [15:0] errorCount;

  fmps_readout_sequencer #(.INDEX_WIDTH(5), .TIMEOUT_CYCLES(300), .DATA_MAGIC(16'hCACA)) dut (
    .auroraClk(auroraClk), .auroraReset(auroraReset), .enable(enable), .FAstrobe(FAstrobe),
    .expectedCount(expectedCount), .fmpsBitmap(fmpsBitmap), .fmpsCounter(fmpsCounter),
    .allFMPSpresent(allFMPSpresent), .readoutAddress(readoutAddress), .readoutFMPS(readoutFMPS),
    .M_TVALID(M_TVALID), .M_TDATA(M_TDATA), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
    .cycleDone(cycleDone), .cycleStatus(cycleStatus), .cycleCounter(cycleCounter),
    .errorCount(errorCount)
  );

  always #5 auroraClk = ~auroraClk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [32];
  logic [32:0] beatQ [$];
  bit          stableChk = 1'b1;
  logic        stallSeen = 1'b0;
  logic [32:0] stallBeat = '0;

  // Store model: registered read port, one clock of latency
  always @(posedge auroraClk) readoutFMPS <= mem[readoutAddress];

  always @(posedge auroraClk) begin
    if (!auroraReset && M_TVALID && M_TREADY) beatQ.push_back({M_TLAST, M_TDATA});
    stallSeen <= M_TVALID && !M_TREADY;
    stallBeat <= {M_TLAST, M_TDATA};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge auroraClk) begin
    if (stableChk && stallSeen) begin
      chk("stallValid", 64'(M_TVALID), 64'd1);
      chk("stallBeat", 64'({M_TLAST, M_TDATA}), 64'(stallBeat));
    end
  end

  function automatic logic [31:0] mkHdr(input int idx, input logic [7:0] c);
    return {3'b000, 5'(idx), 16'hCACA, c};
  endfunction

  task automatic loadMem(input logic [7:0] c, input logic [31:0] badMagic,
                         input logic [31:0] badCyc, input logic [31:0] badHdr);
    for (int i = 0; i < 32; i++) begin
      mem[i] = mkHdr(i, c);
      if (badMagic[i]) mem[i][23:8] = 16'hCACB;
      if (badCyc[i])   mem[i][7:0]  = c ^ 8'h5A;
      if (badHdr[i])   mem[i][29]   = 1'b1;
    end
  endtask

  task automatic checkBeats(input logic [31:0] bm);
    int n = 0;
    int hi = -1;
    int k = 0;
    for (int i = 0; i < 32; i++) if (bm[i]) begin n++; hi = i; end
    chk("beatCount", 64'(beatQ.size()), 64'(n));
    for (int i = 0; i < 32; i++) begin
      if (bm[i]) begin
        if (k < beatQ.size()) chk($sformatf("beat%0d", i), 64'(beatQ[k]), 64'({i == hi, mem[i]}));
        k++;
      end
    end
  endtask

  task automatic waitDone(input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge auroraClk);
      if (cycleDone) seen = 1'b1;
    end
    chk("doneSeen", 64'(seen), 64'd1);
  endtask

  typedef struct {
    logic [31:0] bitmap;
    logic [5:0]  expCount;
    logic [5:0]  arrived;
    logic [31:0] badMagic;
    logic [31:0] badCyc;
    logic [31:0] badHdr;
    bit          randReady;
    logic [1:0]  expStatus;
    logic [7:0]  expCyc;
    logic [15:0] expErr;
    int          expRise;
  } vec_t;

  task automatic runCycle(input vec_t v);
    int cyc = 0;
    int rise = -1;
    bit done = 1'b0;
    loadMem(v.expCyc, v.badMagic, v.badCyc, v.badHdr);
    fmpsBitmap = '0; fmpsCounter = '0; expectedCount = v.expCount;
    beatQ.delete();
    FAstrobe = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge auroraClk);
      cyc++;
      FAstrobe = 1'b0;
      if (rise < 0 && allFMPSpresent) rise = cyc - 1;
      if (cycleDone) done = 1'b1;
      if (cyc == 5) begin fmpsBitmap = v.bitmap; fmpsCounter = v.arrived; end
      M_TREADY = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    M_TREADY = 1'b1;
    chk("cycleDone", 64'(done), 64'd1);
    chk("riseDelay", 64'(rise), 64'(v.expRise));
    chk("cycleStatus", 64'(cycleStatus), 64'(v.expStatus));
    chk("cycleCounter", 64'(cycleCounter), 64'(v.expCyc));
    chk("errorCount", 64'(errorCount), 64'(v.expErr));
    chk("presentHeld", 64'(allFMPSpresent), 64'd1);
    checkBeats(v.bitmap);
  endtask

  task automatic checkZero();
    chk("rstPresent", 64'(allFMPSpresent), 64'd0);
    chk("rstAddr", 64'(readoutAddress), 64'd0);
    chk("rstValid", 64'(M_TVALID), 64'd0);
    chk("rstData", 64'(M_TDATA), 64'd0);
    chk("rstLast", 64'(M_TLAST), 64'd0);
    chk("rstDone", 64'(cycleDone), 64'd0);
    chk("rstStatus", 64'(cycleStatus), 64'd0);
    chk("rstCycle", 64'(cycleCounter), 64'd0);
    chk("rstErr", 64'(errorCount), 64'd0);
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    bit seen;
    int n;
    // bitmap, expCount, arrived, badMagic, badCyc, badHdr, randReady, status, cyc, err, rise
    vecs[0] = '{32'h8000_07FF, 6'd12, 6'd12, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 8'd1, 16'd0, 5};
    vecs[1] = '{32'h0000_03FF, 6'd12, 6'd10, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 8'd2, 16'd0, 300};
    vecs[2] = '{32'h8000_07FF, 6'd12, 6'd12, 32'h20, 32'h80, 32'h0, 1'b0, 2'd2, 8'd3, 16'd2, 5};
    vecs[3] = '{32'h8000_07FF, 6'd12, 6'd12, 32'h0, 32'h0, 32'h0, 1'b1, 2'd0, 8'd4, 16'd2, 5};
    vecs[4] = '{32'h0000_0000, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 8'd5, 16'd2, 1};
    vecs[5] = '{32'h0001_0001, 6'd2, 6'd2, 32'h0, 32'h0, 32'h1_0000, 1'b0, 2'd2, 8'd6, 16'd3, 5};
    post    = '{32'h0000_0105, 6'd3, 6'd3, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 8'd1, 16'd0, 5};

    auroraReset = 1'b1; enable = 1'b1; FAstrobe = 1'b0; M_TREADY = 1'b1;
    expectedCount = '0; fmpsCounter = '0; fmpsBitmap = '0;
    loadMem(8'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge auroraClk);
    auroraReset = 1'b0;
    @(negedge auroraClk);
    checkZero();

    for (int i = 0; i < 6; i++) runCycle(vecs[i]);

    // Overrun: second strobe 20 clocks into WAIT, then the new cycle completes
    loadMem(8'd8, 32'h0, 32'h0, 32'h0);
    expectedCount = 6'd12; fmpsBitmap = '0; fmpsCounter = '0;
    beatQ.delete();
    FAstrobe = 1'b1;
    @(negedge auroraClk);
    FAstrobe = 1'b0;
    repeat (20) @(negedge auroraClk);
    FAstrobe = 1'b1;
    @(negedge auroraClk);
    FAstrobe = 1'b0;
    chk("ovrDone", 64'(cycleDone), 64'd1);
    chk("ovrStatus", 64'(cycleStatus), 64'd3);
    chk("ovrErr", 64'(errorCount), 64'd4);
    chk("ovrCycle", 64'(cycleCounter), 64'd8);
    fmpsBitmap = 32'h8000_07FF; fmpsCounter = 6'd12;
    waitDone(500, seen);
    chk("ovrNextStatus", 64'(cycleStatus), 64'd0);
    chk("ovrNextErr", 64'(errorCount), 64'd4);
    checkBeats(32'h8000_07FF);

    // Strobe while a beat is stalled: TLAST forced, status 3 after handshake
    stableChk = 1'b0;
    loadMem(8'd9, 32'h0, 32'h0, 32'h0);
    expectedCount = 6'd3; fmpsBitmap = 32'h7; fmpsCounter = 6'd3; M_TREADY = 1'b0;
    beatQ.delete();
    FAstrobe = 1'b1;
    n = 0;
    do begin @(negedge auroraClk); FAstrobe = 1'b0; n++; end while (!M_TVALID && n < 50);
    chk("sendValid", 64'(M_TVALID), 64'd1);
    chk("sendLastBefore", 64'(M_TLAST), 64'd0);
    FAstrobe = 1'b1;
    @(negedge auroraClk);
    FAstrobe = 1'b0;
    chk("sendLastForced", 64'(M_TLAST), 64'd1);
    chk("sendData", 64'(M_TDATA), 64'(mem[0]));
    M_TREADY = 1'b1;
    @(negedge auroraClk);
    chk("pendDone", 64'(cycleDone), 64'd1);
    chk("pendStatus", 64'(cycleStatus), 64'd3);
    chk("pendErr", 64'(errorCount), 64'd5);
    chk("pendCycle", 64'(cycleCounter), 64'd10);
    chk("pendValid", 64'(M_TVALID), 64'd0);
    chk("pendBeats", 64'(beatQ.size()), 64'd1);

    // Reset in the middle of a stalled beat of the follow-on cycle
    M_TREADY = 1'b0;
    n = 0;
    do begin @(negedge auroraClk); n++; end while (!M_TVALID && n < 50);
    chk("preRstValid", 64'(M_TVALID), 64'd1);
    auroraReset = 1'b1;
    @(negedge auroraClk);
    checkZero();
    auroraReset = 1'b0; M_TREADY = 1'b1;
    @(negedge auroraClk);
    stableChk = 1'b1;
    runCycle(post);

    // enable low drops the freeze and holds the counters
    enable = 1'b0;
    @(negedge auroraClk);
    chk("disPresent", 64'(allFMPSpresent), 64'd0);
    chk("disCycle", 64'(cycleCounter), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
